// File: rtl/req_arbiter_pkg.sv
// Shared types and default sizing for the request arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   NUM_REQ_DEF   : default number of requesters
//   MAX_HOLD_DEF  : default maximum grant hold time in cycles
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   localparam int NUM_REQ_DEF  = 4;
   localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/req_arbiter_prio_enc.sv
// Combinational priority encoder.
//   DIR = 0 : reports the lowest set bit of i_vec
//   DIR = 1 : reports the highest set bit of i_vec
// Ports:
//   i_vec   in   N       input vector
//   o_valid out  1       at least one bit of i_vec is set
//   o_idx   out  IDX_W   index of the selected bit, 0 when o_valid = 0
module prio_enc
   import arb_pkg::*;
#(
   parameter int N     = NUM_REQ_DEF,
   parameter int IDX_W = $clog2(N),
   parameter int DIR   = 0
) (
   input  logic [N-1:0]     i_vec,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int i = 0; i < N; i++) begin
         // Upward scan: lowest form keeps the first hit, highest form keeps the last.
         if (i_vec[i] && ((DIR != 0) || !o_valid)) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/req_arbiter.sv
// Arbiter sharing one downstream resource between NUM_REQ requesters.
// Registered one-hot grants; fixed-priority (highest index wins) or
// round-robin selection chosen per arbitration by rr_mode.
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   rr_mode    in   1        0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   req        in   NUM_REQ  level-sensitive request vector
//   done       in   1        owner finished (used only while granted)
//   gnt        out  NUM_REQ  one-hot grant
//   gnt_valid  out  1        any grant active
//   gnt_id     out  IDX_W    owner index, 0 when idle
//   timeout    out  1        one-cycle pulse after a forced release
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrates the current req vector every cycle
// HOLD  | grant held; waits for done, request drop or hold timeout
module req_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int IDX_W    = $clog2(NUM_REQ),
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rr_mode,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_id,
   output logic               timeout
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   arb_state_t         r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
   logic               r_gnt_valid;
   logic [IDX_W-1:0]   r_gnt_id, w_gnt_id_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
   logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;

   logic [NUM_REQ-1:0] w_mask_req;
   logic               w_m_valid, w_u_valid, w_h_valid;
   logic [IDX_W-1:0]   w_m_idx, w_u_idx, w_h_idx;
   logic               w_any_req;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_hold_last;
   logic               w_owner_req;

   // Round-robin looks first at requesters at or above the pointer.
   assign w_mask_req = req & ~((NUM_REQ'(1) << r_rr_ptr) - NUM_REQ'(1));

   prio_enc #(.N(NUM_REQ), .IDX_W(IDX_W), .DIR(0)) u_enc_masked (
      .i_vec   (w_mask_req),
      .o_valid (w_m_valid),
      .o_idx   (w_m_idx)
   );

   prio_enc #(.N(NUM_REQ), .IDX_W(IDX_W), .DIR(0)) u_enc_unmasked (
      .i_vec   (req),
      .o_valid (w_u_valid),
      .o_idx   (w_u_idx)
   );

   prio_enc #(.N(NUM_REQ), .IDX_W(IDX_W), .DIR(1)) u_enc_high (
      .i_vec   (req),
      .o_valid (w_h_valid),
      .o_idx   (w_h_idx)
   );

   assign w_any_req   = rr_mode ? w_u_valid : w_h_valid;
   assign w_win_idx   = rr_mode ? (w_m_valid ? w_m_idx : w_u_idx) : w_h_idx;
   assign w_hold_last = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
   assign w_owner_req = req[r_gnt_id];

   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_gnt_id_nxt   = r_gnt_id;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_hold_cnt_nxt = r_hold_cnt;
      w_timeout_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt    = HOLD;
               w_gnt_nxt      = NUM_REQ'(1) << w_win_idx;
               w_gnt_id_nxt   = w_win_idx;
               w_hold_cnt_nxt = '0;
            end
         end
         HOLD: begin
            if (done || !w_owner_req || w_hold_last) begin
               w_state_nxt    = IDLE;
               w_gnt_nxt      = '0;
               w_gnt_id_nxt   = '0;
               w_hold_cnt_nxt = '0;
               w_rr_ptr_nxt   = (r_gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + IDX_W'(1);
               // Only a release caused purely by the hold limit counts as forced.
               w_timeout_nxt  = !done && w_owner_req;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_timeout   <= 1'b0;
         r_rr_ptr    <= '0;
         r_hold_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_gnt_valid <= |w_gnt_nxt;
         r_gnt_id    <= w_gnt_id_nxt;
         r_timeout   <= w_timeout_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_hold_cnt  <= w_hold_cnt_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gnt_valid;
   assign gnt_id    = r_gnt_id;
   assign timeout   = r_timeout;

endmodule
